// File: rtl/seg7_pkg.sv
// Shared types and segment patterns for the 7-segment scan controller.
// Patterns are {a,b,c,d,e,f,g}, active-high for a common-cathode display.
package seg7_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [3:0] bcd_t;

    localparam seg_t SEG_0     = 7'b1111110;
    localparam seg_t SEG_1     = 7'b0110000;
    localparam seg_t SEG_2     = 7'b1101101;
    localparam seg_t SEG_3     = 7'b1111001;
    localparam seg_t SEG_4     = 7'b0110011;
    localparam seg_t SEG_5     = 7'b1011011;
    localparam seg_t SEG_6     = 7'b1011111;
    localparam seg_t SEG_7     = 7'b1110000;
    localparam seg_t SEG_8     = 7'b1111111;
    localparam seg_t SEG_9     = 7'b1111011;
    localparam seg_t SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to segment pattern decoder.
// Codes 10..15 have no glyph and decode to all segments off.
module seg7_decode
    import seg7_pkg::*;
(
    input  bcd_t bcd,
    output seg_t seg
);

    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a common-cathode multi-digit 7-segment display.
// Define SEG7_LZB_EN to blank leading zero digits (digit 0 always shown).
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 50000,
    parameter int BLANK_CYC  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    upd_valid,
    output logic                    upd_ready,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg
);

    localparam int TICK_W = $clog2(CLK_DIV);
    localparam int DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_DIV - 1);
    localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(NUM_DIGITS - 1);

    logic [TICK_W-1:0]       tick_cnt;
    logic [DIG_W-1:0]        dig_idx;
    logic [4*NUM_DIGITS-1:0] disp_reg;
    logic [4*NUM_DIGITS-1:0] pend_reg;
    logic                    pend_flag;

    logic                    slot_end;
    logic                    frame_end;
    logic                    xfer;
    logic                    commit;
    logic                    blanking;
    logic [NUM_DIGITS-1:0]   lit_mask;
    logic                    dig_lit;
    bcd_t                    cur_dig;
    seg_t                    cur_seg;

    assign slot_end  = (tick_cnt == TICK_LAST);
    assign frame_end = slot_end && (dig_idx == DIG_LAST);
    assign xfer      = upd_valid & ~pend_flag;
    // Commit only on a frame boundary so a frame never mixes old and new digits.
    assign commit    = frame_end & pend_flag;
    assign blanking  = (tick_cnt < TICK_W'(BLANK_CYC));
    assign upd_ready = ~pend_flag;

`ifdef SEG7_LZB_EN
    logic nz_seen;

    // A digit stays lit if it or any more significant digit is nonzero.
    always_comb begin
        nz_seen  = 1'b0;
        lit_mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            nz_seen     = nz_seen | (disp_reg[4*i +: 4] != 4'd0);
            lit_mask[i] = nz_seen;
        end
        lit_mask[0] = 1'b1;
    end
`else
    assign lit_mask = '1;
`endif

    always_comb begin
        cur_dig = '0;
        dig_lit = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (dig_idx == DIG_W'(i)) begin
                cur_dig = disp_reg[4*i +: 4];
                dig_lit = lit_mask[i];
            end
        end
    end

    seg7_decode u_decode (
        .bcd (cur_dig),
        .seg (cur_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt  <= '0;
            dig_idx   <= '0;
            disp_reg  <= '0;
            pend_reg  <= '0;
            pend_flag <= 1'b0;
            an        <= '0;
            seg       <= SEG_BLANK;
        end else begin
            tick_cnt <= slot_end ? '0 : tick_cnt + 1'b1;
            if (slot_end) begin
                dig_idx <= (dig_idx == DIG_LAST) ? '0 : dig_idx + 1'b1;
            end

            if (commit) begin
                disp_reg  <= pend_reg;
                pend_flag <= 1'b0;
            end else if (xfer) begin
                pend_reg  <= bcd_in;
                pend_flag <= 1'b1;
            end

            // Output stage: registered view of this cycle's counters and display value.
            if (blanking || !dig_lit) begin
                an  <= '0;
                seg <= SEG_BLANK;
            end else begin
                an  <= NUM_DIGITS'(1) << dig_idx;
                seg <= cur_seg;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed self-checking bench for seg7_scan_ctrl (4 digits, 8-cycle slots, 2 blank cycles).
// Build with SEG7_LZB_EN defined to also cover leading-zero blanking.
module tb_seg7_scan_ctrl;

    localparam int ND = 4;
    localparam int CD = 8;
    localparam int BC = 2;
    localparam int FRAME = ND * CD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        upd_valid = 1'b0;
    logic        upd_ready;
    logic [15:0] bcd_in = 16'h0000;
    logic [3:0]  an;
    logic [6:0]  seg;

    int          checks = 0;
    int          failures = 0;
    int          n = 0;
    int          base = 0;
    logic [15:0] disp_now = 16'h0000;
    logic [15:0] disp_last = 16'h0000;
    logic [15:0] sched = 16'h0000;
    logic        sched_vld = 1'b0;
    logic        exp_rdy = 1'b1;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(
        .NUM_DIGITS (ND),
        .CLK_DIV    (CD),
        .BLANK_CYC  (BC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .upd_valid (upd_valid),
        .upd_ready (upd_ready),
        .bcd_in    (bcd_in),
        .an        (an),
        .seg       (seg)
    );

    function automatic logic [6:0] dec(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1111110;
            4'd1:    return 7'b0110000;
            4'd2:    return 7'b1101101;
            4'd3:    return 7'b1111001;
            4'd4:    return 7'b0110011;
            4'd5:    return 7'b1011011;
            4'd6:    return 7'b1011111;
            4'd7:    return 7'b1110000;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    // n counts edges since reset release; a value scheduled by the script
    // becomes the displayed value in the interval right after a frame boundary.
    task automatic step();
        @(posedge clk);
        #1;
        n++;
        disp_last = disp_now;
        if ((n % FRAME == 0) && sched_vld) begin
            disp_now  = sched;
            sched_vld = 1'b0;
            exp_rdy   = 1'b1;
        end
    endtask

    task automatic chk(input string tag);
        int         s;
        int         tick;
        int         dig;
        logic       lit;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        e_an  = 4'b0000;
        e_seg = 7'b0000000;
        if (n > 0) begin
            s    = n - 1;
            tick = s % CD;
            dig  = (s / CD) % ND;
            lit  = 1'b1;
`ifdef SEG7_LZB_EN
            lit = (dig == 0) || ((disp_last >> (4 * dig)) != 16'h0000);
`endif
            if (tick >= BC && lit) begin
                e_an  = 4'b0001 << dig;
                e_seg = dec(disp_last[4*dig +: 4]);
            end
        end
        checks++;
        assert (an === e_an) else begin
            failures++;
            $error("FAIL %s an n=%0d got=%b exp=%b", tag, n, an, e_an);
        end
        checks++;
        assert (seg === e_seg) else begin
            failures++;
            $error("FAIL %s seg n=%0d got=%b exp=%b", tag, n, seg, e_seg);
        end
        checks++;
        assert (upd_ready === exp_rdy) else begin
            failures++;
            $error("FAIL %s upd_ready n=%0d got=%b exp=%b", tag, n, upd_ready, exp_rdy);
        end
    endtask

    task automatic run_to(input int target, input string tag);
        while (n < target) begin
            step();
            chk(tag);
        end
    endtask

    task automatic offer(input logic [15:0] v, input string tag);
        upd_valid = 1'b1;
        bcd_in    = v;
        step();
        upd_valid = 1'b0;
        exp_rdy   = 1'b0;
        sched     = v;
        sched_vld = 1'b1;
        chk(tag);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset");
        rst = 1'b0;

        run_to(FRAME, "idle_zero");

        run_to(44, "pre_1234");
        offer(16'h1234, "accept_1234");
        run_to(97, "show_1234");

        run_to(100, "pre_5678");
        upd_valid = 1'b1;
        bcd_in    = 16'h5678;
        step();
        exp_rdy   = 1'b0;
        sched     = 16'h5678;
        sched_vld = 1'b1;
        chk("accept_5678");
        run_to(105, "hold_5678");
        bcd_in = 16'h9999;
        run_to(128, "hold_9999");
        step();
        upd_valid = 1'b0;
        exp_rdy   = 1'b0;
        sched     = 16'h9999;
        sched_vld = 1'b1;
        chk("accept_9999");
        run_to(193, "show_9999");

        offer(16'h00AF, "accept_00af");
        run_to(257, "show_00af");

`ifdef SEG7_LZB_EN
        offer(16'h0070, "accept_0070");
        run_to(321, "lzb_0070");
        offer(16'h0000, "accept_0000");
        run_to(385, "lzb_0000");
`endif

        // Leave an update pending, then reset in the middle of a digit-2 slot.
        upd_valid = 1'b1;
        bcd_in    = 16'h4321;
        step();
        upd_valid = 1'b0;
        exp_rdy   = 1'b0;
        chk("accept_4321");
        base = (n / FRAME) * FRAME;
        run_to(base + 2 * CD + 4, "pre_rst");
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        n         = 0;
        disp_now  = 16'h0000;
        disp_last = 16'h0000;
        sched_vld = 1'b0;
        exp_rdy   = 1'b1;
        chk("mid_reset");
        run_to(FRAME + 8, "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan controller for a multi-digit common-cathode 7-segment display. It holds a packed multi-digit BCD value and steps one digit at a time through an internal BCD-to-segment decoder. It drives the shared segment bus plus one active-high digit-enable line per digit. It sits between any value producer (counter, register file, UART sink) and the board-level display pins.

## Interface
- `NUM_DIGITS`, 4: number of digits scanned; legal range 1..8.
- `CLK_DIV`, 50000: clock cycles per digit slot; must be ≥ 2.
- `BLANK_CYC`, 4: cycles at the start of each slot with all digits off (anti-ghosting); must be < `CLK_DIV`.
- `clk` in 1: single clock. All logic is rising-edge.
- `rst` in 1: reset, synchronous, active-high.
- `upd_valid` in 1: new display value offered on `bcd_in`.
- `upd_ready` out 1: controller can accept a new value.
- `bcd_in` in 4*NUM_DIGITS: packed BCD. Digit 0 (least significant) is in bits [3:0].
- `an` out NUM_DIGITS: digit enables, active-high. At most one bit is set.
- `seg` out 7: segments {a,b,c,d,e,f,g}, active-high (common cathode).

## Operation
- Counters:
  - `tick_cnt` runs 0..CLK_DIV-1.
  - At wrap, `dig_idx` advances 0→1→…→NUM_DIGITS-1→0.
- Frame boundary: the cycle where `tick_cnt`=CLK_DIV-1 and `dig_idx`=NUM_DIGITS-1.
- Registers:
  - `disp_reg`: the value currently shown.
  - `pend_reg` plus `pend_flag`: an accepted update that has not yet been shown.
- Handshake:
  - Transfer occurs when `upd_valid & upd_ready`. The data goes to `pend_reg`, and `pend_flag` is set.
  - `upd_ready` equals `~pend_flag` (registered).
  - `upd_valid` may be held or dropped freely while `upd_ready`=0; nothing is captured.
- Commit:
  - At a frame boundary with `pend_flag`=1 (value at the start of that cycle), `disp_reg` ← `pend_reg` and `pend_flag` clears.
  - A transfer in the frame-boundary cycle itself commits at the next frame boundary.
  - Result: whole frames only, no tearing.
- Per-slot output:
  - `tick_cnt` < BLANK_CYC: `an`=0 and `seg`=0.
  - Otherwise: `an` is one-hot at `dig_idx`, and `seg` = decode(`disp_reg` digit `dig_idx`).
- Decode (common cathode):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - 10..15 = 0000000 (blank; `an` still asserted).
- `NUM_DIGITS`=1: every slot end is a frame boundary.

## Timing
- Reset values:
  - `an`=0, `seg`=0, `upd_ready`=1.
  - `tick_cnt`=0, `dig_idx`=0.
  - `disp_reg`=0, `pend_reg`=0, `pend_flag`=0.
- After reset the display shows all zeros (subject to blanking by `SEG7_LZB_EN`).
- `an` and `seg` are registered. The outputs in cycle t+1 reflect the counter and `disp_reg` state in cycle t: one-cycle latency.
- First cycle after `rst` falls: counters are 0. `an` first goes nonzero BLANK_CYC+1 cycles after reset release.
- Update to display latency: between 1 and NUM_DIGITS*CLK_DIV+1 cycles after commit eligibility. The new digit is visible on `seg` one cycle after the commit cycle if that slot is past blanking.
- `upd_ready` falls the cycle after a transfer. It rises the cycle after the commit.
- `rst` asserted mid-frame: next edge forces all reset values. Any pending update is discarded.

## Configuration
- `SEG7_LZB_EN` (leading-zero blanking).
  - Defined: digits above the most significant nonzero digit of `disp_reg` drive `an`=0 and `seg`=0 during their slot. Digit 0 is never blanked. Slot timing is unchanged.
  - Undefined: every digit is shown, including leading zeros.

## Structure
- Package `seg7_pkg`:
  - `seg_t` (logic [6:0]).
  - Constants `SEG_0`..`SEG_9` and `SEG_BLANK`.
  - Function or typedef for BCD digit `bcd_t` (logic [3:0]).
- Sub-module `seg7_decode`: purely combinational `bcd_t` → `seg_t`, active-high, blank on 10..15. It is instantiated once and fed by the digit mux.
- Counters, handshake, commit, LZB mask and output registers live in `seg7_scan_ctrl`.

## Test plan
Bench parameters: NUM_DIGITS=4, CLK_DIV=8, BLANK_CYC=2.
- Reset, then run 32 cycles → `an` sequence per 8-cycle slot: 0,0, then 0001×6; next slot 0,0, then 0010×6; … `seg`=1111110 whenever `an`≠0, `upd_ready`=1.
- Offer 16'h1234 mid-slot of digit 1 → `upd_ready`=0 next cycle. Digits keep showing 0 until the frame boundary. Next frame shows 4,3,2,1 as 0110011, 1111001, 1101101, 0110000. `upd_ready`=1 the cycle after commit.
- Hold `upd_valid`=1 with 16'h5678 while `upd_ready`=0, then offer 16'h9999 → only 5678 is captured. 9999 is captured after `upd_ready` returns and is shown one frame later.
- Offer 16'h00AF → digit 0 (F) and digit 1 (A) show `seg`=0000000 with `an` asserted.
- With `SEG7_LZB_EN`, offer 16'h0070 → digits 3 and 2 have `an`=0. Digit 1 shows 1110000 and digit 0 shows 1111110. Offer 16'h0000 → only digit 0 is lit.
- Assert `rst` for 1 cycle during a digit-2 slot with an update pending → all outputs at reset values next cycle. Display returns to zeros and `upd_ready`=1.
